// File: rtl/pipelined_barrel_shifter_with_handshake_if.sv
// pipelined_barrel_shifter_with_handshake_if: valid/ready bus carrying operands in and shifted results out
// up_*: operand, shift amount, direction, arithmetic select with up_valid/up_ready handshake
// down_*: shifted result with down_valid/down_ready handshake
// slave = the shifter, master = the producer/consumer side
interface pipelined_barrel_shifter_with_handshake_if #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
);
    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  up_data;
    logic [SW-1:0] up_shamt;
    logic          up_dir;
    logic          up_arith;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_data;
    modport master (
        output up_valid, up_data, up_shamt, up_dir, up_arith, down_ready,
        input  up_ready, down_valid, down_data
    );
    modport slave (
        input  up_valid, up_data, up_shamt, up_dir, up_arith, down_ready,
        output up_ready, down_valid, down_data
    );
endinterface

// File: rtl/pipelined_barrel_shifter_with_handshake.sv
// pipelined_barrel_shifter_with_handshake: log2(N)-stage barrel shifter with valid/ready flow control
// clk: rising-edge clock; rst_n: asynchronous active-low reset
// bus: slave side of the shifter interface (operands in on up_*, results out on down_*)
module pipelined_barrel_shifter_with_handshake #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input logic clk,
    input logic rst_n,
    pipelined_barrel_shifter_with_handshake_if.slave bus
);
    logic [SW-1:0] r_valid;
    logic [SW-1:0] r_dir;
    logic [SW-1:0] r_fill;
    logic [N-1:0]  r_data [SW];
    logic [SW-1:0] r_shamt [SW];
    logic [SW-1:0] w_ready;
    logic [SW-1:0] w_in_valid;
    logic [SW-1:0] w_in_dir;
    logic [SW-1:0] w_in_fill;
    logic [N-1:0]  w_in_data [SW];
    logic [N-1:0]  w_shifted [SW];
    logic [SW-1:0] w_in_shamt [SW];
    genvar i;
    generate
        for (i = 0; i < SW; i++) begin : g_stage
            localparam int D = 1 << i;
            if (i == 0) begin : g_head
                assign w_in_valid[i] = bus.up_valid;
                assign w_in_data[i]  = bus.up_data;
                assign w_in_shamt[i] = bus.up_shamt;
                assign w_in_dir[i]   = bus.up_dir;
                assign w_in_fill[i]  = bus.up_dir & bus.up_arith & bus.up_data[N-1];
            end else begin : g_body
                assign w_in_valid[i] = r_valid[i-1];
                assign w_in_data[i]  = r_data[i-1];
                assign w_in_shamt[i] = r_shamt[i-1];
                assign w_in_dir[i]   = r_dir[i-1];
                assign w_in_fill[i]  = r_fill[i-1];
            end
            // a stage can load unless it and every stage after it are full and the consumer stalls
            assign w_ready[i]   = bus.down_ready | ~&r_valid[SW-1:i];
            // the carried shift amount is pre-shifted so bit 0 always belongs to the current stage
            assign w_shifted[i] = !w_in_shamt[i][0] ? w_in_data[i] :
                                  w_in_dir[i] ? {{D{w_in_fill[i]}}, w_in_data[i][N-1:D]} :
                                  {w_in_data[i][N-1-D:0], {D{1'b0}}};
        end
    endgenerate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dir   <= '0;
            r_fill  <= '0;
            for (int k = 0; k < SW; k++) begin
                r_data[k]  <= '0;
                r_shamt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SW; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_in_valid[k];
                    r_data[k]  <= w_shifted[k];
                    r_shamt[k] <= w_in_shamt[k] >> 1;
                    r_dir[k]   <= w_in_dir[k];
                    r_fill[k]  <= w_in_fill[k];
                end
            end
        end
    end
    assign bus.up_ready   = w_ready[0];
    assign bus.down_valid = r_valid[SW-1];
    assign bus.down_data  = r_data[SW-1];
endmodule

// File: tb/tb_pipelined_barrel_shifter_with_handshake.sv
// tb_pipelined_barrel_shifter_with_handshake: vector table plus scoreboard bench for the pipelined shifter
module tb_pipelined_barrel_shifter_with_handshake;
    localparam int N  = 8;
    localparam int SW = 3;
    typedef struct {
        logic [N-1:0]  a;
        logic [SW-1:0] s;
        logic          dir;
        logic          arith;
        logic [N-1:0]  exp;
    } vec_t;
    vec_t vecs [9];
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int nin    = 0;
    int nout   = 0;
    logic [N-1:0] sb [$];
    logic [N-1:0] cur_exp;
    logic [N-1:0] mon_e;
    pipelined_barrel_shifter_with_handshake_if #(.N(N)) bus ();
    pipelined_barrel_shifter_with_handshake #(.N(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    function automatic logic [N-1:0] model(logic [N-1:0] a, logic [SW-1:0] s, logic dir, logic arith);
        if (!dir) return a << s;
        if (arith) return $signed(a) >>> s;
        return a >> s;
    endfunction
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.down_valid && bus.down_ready) begin
                nout++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got %h expected none at %0t", bus.down_data, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("scoreboard", 32'(bus.down_data), 32'(mon_e));
                end
            end
            if (bus.up_valid && bus.up_ready) begin
                sb.push_back(cur_exp);
                nin++;
            end
        end
    end
    task automatic drive(input logic [N-1:0] a, input logic [SW-1:0] s, input logic dir, input logic arith, input logic [N-1:0] exp);
        bus.up_valid = 1'b1;
        bus.up_data  = a;
        bus.up_shamt = s;
        bus.up_dir   = dir;
        bus.up_arith = arith;
        cur_exp      = exp;
    endtask
    task automatic send(input logic [N-1:0] a, input logic [SW-1:0] s, input logic dir, input logic arith, input logic [N-1:0] exp);
        int n = 0;
        drive(a, s, dir, arith, exp);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.up_ready && n < 200);
        if (!bus.up_ready) chk("send_timeout", 32'(bus.up_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
    endtask
    task automatic wait_drain();
        int n = 0;
        bus.down_ready = 1'b1;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask
    task automatic lat_check(input logic [N-1:0] a, input logic [SW-1:0] s, input logic dir, input logic arith, input logic [N-1:0] exp);
        drive(a, s, dir, arith, exp);
        @(negedge clk);
        chk("lat_up_ready", 32'(bus.up_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
        chk("lat_valid_c1", 32'(bus.down_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_c2", 32'(bus.down_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_c3", 32'(bus.down_valid), 32'd1);
        chk("lat_data", 32'(bus.down_data), 32'(exp));
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [N-1:0]  a;
        logic [N-1:0]  keep;
        logic [N-1:0]  e0;
        logic [SW-1:0] s;
        logic          d;
        logic          ar;
        int            acc;
        int            nin0;
        int            nout0;
        time           t0;
        bit            done;
        vecs[0] = '{8'h96, 3'd3, 1'b0, 1'b0, 8'hB0};
        vecs[1] = '{8'h96, 3'd3, 1'b1, 1'b0, 8'h12};
        vecs[2] = '{8'h96, 3'd3, 1'b1, 1'b1, 8'hF2};
        vecs[3] = '{8'h70, 3'd7, 1'b1, 1'b1, 8'h00};
        vecs[4] = '{8'h80, 3'd7, 1'b1, 1'b1, 8'hFF};
        vecs[5] = '{8'h96, 3'd0, 1'b1, 1'b1, 8'h96};
        vecs[6] = '{8'h01, 3'd7, 1'b0, 1'b0, 8'h80};
        vecs[7] = '{8'hFF, 3'd4, 1'b0, 1'b1, 8'hF0};
        vecs[8] = '{8'h80, 3'd1, 1'b1, 1'b0, 8'h40};
        bus.up_valid   = 1'b0;
        bus.up_data    = '0;
        bus.up_shamt   = '0;
        bus.up_dir     = 1'b0;
        bus.up_arith   = 1'b0;
        bus.down_ready = 1'b1;
        cur_exp        = '0;
        #2;
        chk("reset_up_ready", 32'(bus.up_ready), 32'd1);
        chk("reset_down_valid", 32'(bus.down_valid), 32'd0);
        chk("reset_down_data", 32'(bus.down_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat_check(8'h96, 3'd3, 1'b0, 1'b0, 8'hB0);
        foreach (vecs[k]) send(vecs[k].a, vecs[k].s, vecs[k].dir, vecs[k].arith, vecs[k].exp);
        wait_drain();
        bus.down_ready = 1'b0;
        acc = 0;
        for (int j = 0; j < 3; j++) begin
            a = 8'hC3 ^ 8'(j * 37);
            s = 3'(j + 1);
            if (j == 0) e0 = model(a, s, 1'b1, 1'b1);
            drive(a, s, 1'b1, 1'b1, model(a, s, 1'b1, 1'b1));
            @(negedge clk);
            acc += int'(bus.up_ready);
            @(posedge clk);
            #1;
        end
        drive(8'h5A, 3'd2, 1'b0, 1'b0, model(8'h5A, 3'd2, 1'b0, 1'b0));
        @(negedge clk);
        chk("bp_full_ready", 32'(bus.up_ready), 32'd0);
        chk("bp_valid", 32'(bus.down_valid), 32'd1);
        keep = bus.down_data;
        chk("bp_head", 32'(keep), 32'(e0));
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("bp_stall_ready", 32'(bus.up_ready), 32'd0);
            chk("bp_stable", 32'(bus.down_data), 32'(keep));
        end
        chk("bp_accepted", 32'(acc), 32'd3);
        @(posedge clk);
        #1;
        bus.down_ready = 1'b1;
        @(negedge clk);
        chk("bp_stream", 32'(bus.down_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stream", 32'(bus.down_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        wait_drain();
        t0 = $time;
        for (int j = 0; j < 20; j++) begin
            a  = 8'($urandom);
            s  = (j % 5 == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            d  = 1'($urandom);
            ar = 1'($urandom);
            send(a, s, d, ar, (s == 0) ? a : model(a, s, d, ar));
        end
        chk("stream_cycles", 32'(($time - t0) / 10), 32'd20);
        wait_drain();
        nin0  = nin;
        nout0 = nout;
        done  = 1'b0;
        fork
            begin
                for (int j = 0; j < 1000; j++) begin
                    a  = 8'($urandom);
                    s  = 3'($urandom_range(0, 7));
                    d  = 1'($urandom);
                    ar = 1'($urandom);
                    send(a, s, d, ar, model(a, s, d, ar));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.down_ready = 1'($urandom);
                end
            end
        join
        wait_drain();
        chk("random_in", 32'(nin - nin0), 32'd1000);
        chk("random_out", 32'(nout - nout0), 32'd1000);
        bus.down_ready = 1'b0;
        for (int j = 0; j < 3; j++) send(8'h81 + 8'(j), 3'd1, 1'b1, 1'b1, model(8'h81 + 8'(j), 3'd1, 1'b1, 1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_up_ready", 32'(bus.up_ready), 32'd1);
        chk("midrst_down_valid", 32'(bus.down_valid), 32'd0);
        chk("midrst_down_data", 32'(bus.down_data), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        bus.down_ready = 1'b1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale", 32'(bus.down_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        lat_check(8'h96, 3'd3, 1'b1, 1'b1, 8'hF2);
        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
